imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Program loader: the write side of the byte-addressed instruction memory.
//  Accepts 16-bit instruction words over a valid/ready stream and writes each one
//  as two big-endian bytes into the 8-bit-wide memory array: high byte at A,
//  low byte at A+1, matching the fetch path. CpuHold keeps the CPU stalled
//  while a load is in progress.
// PARAMETERS
//  DEPTH      128    memory size in bytes; must be even
//  ADDR_W     16     width of MemAddr; same width as the PC
//  BASE_ADDR  0      byte address of the first word; must be even
// PORTS
//  Clock      in   1       rising-edge clock
//  ResetN     in   1       asynchronous, active-low reset
//  Start      in   1       1-cycle pulse; begins a load from BASE_ADDR
//  WordValid  in   1       WordIn/WordLast are valid
//  WordIn     in   16      instruction word, [15:8] is the high byte
//  WordLast   in   1       the current word is the final word of the program
//  WordReady  out  1       loader accepts a word this cycle
//  MemWE      out  1       byte write enable to the memory array
//  MemAddr    out  ADDR_W  byte write address
//  MemData    out  8       byte write data
//  CpuHold    out  1       1 while the FSM is not IDLE/DONE/ERR
//  Done       out  1       load finished normally; sticky until next Start
//  Overflow   out  1       program exceeded memory; sticky until next Start
//  WordCount  out  ADDR_W  number of words fully written in the current load
// BEHAVIOUR
//  Reset (ResetN=0, async): state=IDLE; ptr=BASE_ADDR; every output is 0.
//   A reset mid-load aborts the load; any bytes already written stay in memory.
//  FSM states: IDLE, WAIT, WR_HI, WR_LO, DONE, ERR.
//   IDLE/DONE/ERR + Start   -> WAIT; ptr=BASE_ADDR; WordCount, Done, Overflow cleared.
//   WAIT: WordReady=1 (only in this state). On WordValid&&WordReady, latch
//     WordIn and WordLast -> WR_HI.
//   WR_HI: MemWE=1, MemAddr=ptr, MemData=word[15:8] -> WR_LO.
//   WR_LO: MemWE=1, MemAddr=ptr+1, MemData=word[7:0]; ptr+=2; WordCount+=1.
//     Next state: if last latched -> DONE (Done=1);
//     else if ptr+2==DEPTH -> ERR (Overflow=1);
//     else -> WAIT.
//  A word whose WordLast=1 lands exactly in the last slot (DEPTH-2,DEPTH-1):
//   this is a normal DONE, not an overflow.
//  Start outside IDLE/DONE/ERR is ignored. Start and WordValid in the same
//   cycle: only Start acts, and WordReady=0 that cycle.
//  MemWE is registered, and MemAddr/MemData are stable for every cycle MemWE=1.
//   When MemWE=0, MemAddr and MemData hold their previous values.
//  Throughput: 3 cycles per word at best (WAIT, WR_HI, WR_LO). WordValid may
//   stay high back-to-back; it is sampled only in WAIT.
//  WordValid while not in WAIT: the word is not consumed, and the producer
//   must hold it until WordReady=1.
//  MemAddr never reaches DEPTH; there is no wrap-around, because ERR stops writes.
//  CpuHold=1 in WAIT, WR_HI and WR_LO; 0 in IDLE, DONE and ERR.
// TESTING
//  1 Reset, Start, words 16'hA1B2,16'hC3D4(last) -> writes (0,A1),(1,B2),
//    (2,C3),(3,D4); Done=1; WordCount=2; CpuHold falls the cycle after the WR_LO of 16'hC3D4.
//  2 Stream 64 words, WordLast on the 64th (DEPTH=128) -> last write at addr 127;
//    Done=1; Overflow=0.
//  3 Stream 65 words with no WordLast -> 64 words written; ERR; Overflow=1;
//    word 65 is never accepted (WordReady stays 0).
//  4 Assert ResetN=0 during WR_HI of word 3 -> all outputs 0 immediately;
//    a new Start reloads from BASE_ADDR.
//  5 WordValid held high continuously -> exactly one acceptance every 3 cycles;
//    a Start pulse during WR_LO is ignored.
//  6 BASE_ADDR=16, one word 16'h1234 (last) -> writes (16,12),(17,34); Done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Write side of the byte-addressed instruction memory: takes 16-bit words from a
// valid/ready stream and stores each as two big-endian bytes, stalling the CPU meanwhile.
module imem_loader #(
  parameter int DEPTH     = 128,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              word_valid,
  input  logic [15:0]       word_in,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] word_count
);

  // state  | meaning
  // IDLE   | no load since reset
  // WAIT   | ready for the next word
  // WR_HI  | writing high byte at ptr
  // WR_LO  | writing low byte at ptr+1, then advance
  // DONE   | load ended on a last word
  // ERR    | memory full before a last word arrived
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WR_HI,
    S_WR_LO,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   END_PTR = (ADDR_W+1)'(DEPTH);

  state_t            state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic [7:0]        lo_q, lo_d;
  logic              last_q, last_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_data_d;
  logic              done_d;
  logic              overflow_d;
  logic [ADDR_W-1:0] word_count_d;
  logic [ADDR_W:0]   ptr_next;

  // one bit wider so the end-of-memory compare cannot wrap
  assign ptr_next = {1'b0, ptr} + (ADDR_W+1)'(2);

  assign word_ready = (state == S_WAIT);
  assign cpu_hold   = (state == S_WAIT) || (state == S_WR_HI) || (state == S_WR_LO);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ptr        <= BASE;
      lo_q       <= '0;
      last_q     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      lo_q       <= lo_d;
      last_q     <= last_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_data   <= mem_data_d;
      done       <= done_d;
      overflow   <= overflow_d;
      word_count <= word_count_d;
    end
  end

  // write strobe and bus are computed one state ahead so they are flop outputs
  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    lo_d         = lo_q;
    last_d       = last_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_data_d   = mem_data;
    done_d       = done;
    overflow_d   = overflow;
    word_count_d = word_count;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_WAIT;
          ptr_d        = BASE;
          word_count_d = '0;
          done_d       = 1'b0;
          overflow_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (word_valid) begin
          state_d    = S_WR_HI;
          lo_d       = word_in[7:0];
          last_d     = word_last;
          mem_we_d   = 1'b1;
          mem_addr_d = ptr;
          mem_data_d = word_in[15:8];
        end
      end
      S_WR_HI: begin
        state_d    = S_WR_LO;
        mem_we_d   = 1'b1;
        mem_addr_d = ptr + ADDR_W'(1);
        mem_data_d = lo_q;
      end
      S_WR_LO: begin
        ptr_d        = ptr_next[ADDR_W-1:0];
        word_count_d = word_count + ADDR_W'(1);
        if (last_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (ptr_next == END_PTR) begin
          state_d    = S_ERR;
          overflow_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: hand sequences for timing corners, a table of load shapes,
// and random loads checked against a word-level model of the memory image.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, word_valid, word_last;
  logic [15:0] word_in;
  logic        word_ready, mem_we, cpu_hold, done, overflow;
  logic [15:0] mem_addr, word_count;
  logic [7:0]  mem_data;

  logic        start1, word_valid1, word_last1;
  logic [15:0] word_in1;
  logic        word_ready1, mem_we1, cpu_hold1, done1, overflow1;
  logic [15:0] mem_addr1, word_count1;
  logic [7:0]  mem_data1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [23:0] log0[$];
  logic [23:0] log1[$];

  imem_loader #(.DEPTH(128), .ADDR_W(16), .BASE_ADDR(0)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .word_valid(word_valid),
    .word_in(word_in), .word_last(word_last), .word_ready(word_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .done(done), .overflow(overflow), .word_count(word_count)
  );

  imem_loader #(.DEPTH(128), .ADDR_W(16), .BASE_ADDR(16)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .word_valid(word_valid1),
    .word_in(word_in1), .word_last(word_last1), .word_ready(word_ready1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_data(mem_data1),
    .cpu_hold(cpu_hold1), .done(done1), .overflow(overflow1), .word_count(word_count1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (mem_we) begin
      log0.push_back({mem_addr, mem_data});
      n_tests++;
      if (mem_addr >= 16'd128) begin
        n_fail++;
        $display("FAIL addr_range: got %0d required < 128", mem_addr);
      end
    end
    if (mem_we1) log1.push_back({mem_addr1, mem_data1});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // word-level reference: each accepted word occupies the next 2-byte slot;
  // the load ends on the last word or when the final slot has been filled
  function automatic void model(input int n, input int last_idx, input int base,
                                output int acc, output bit dn, output bit ov);
    acc = 0; dn = 1'b0; ov = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!dn && !ov) begin
        acc++;
        if (i == last_idx) dn = 1'b1;
        else if (base + 2 * acc == 128) ov = 1'b1;
      end
    end
  endfunction

  // call just after a negedge with the DUT in IDLE/DONE/ERR
  task automatic run_load(input int n, input int last_idx, input int exp_acc,
                          input bit exp_done, input bit exp_ovf, input string tag);
    logic [15:0] words[80];
    int i, budget, gap, errs;
    for (int k = 0; k < n; k++) words[k] = 16'($urandom);
    log0.delete();
    start = 1'b1;
    word_valid = 1'($urandom_range(0, 1));
    word_in = words[0];
    word_last = 1'b0;
    @(negedge clock);
    start = 1'b0;
    i = 0;
    while (i < n) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        word_valid = 1'b0;
        repeat (gap) @(negedge clock);
      end
      word_valid = 1'b1;
      word_in = words[i];
      word_last = (i == last_idx);
      budget = 0;
      while (!word_ready && cpu_hold && budget < 10) begin
        @(negedge clock);
        budget++;
      end
      if (!word_ready) break;
      @(negedge clock);
      i++;
    end
    word_valid = 1'b0;
    word_last = 1'b0;
    budget = 0;
    while (cpu_hold && budget < 10) begin
      @(negedge clock);
      budget++;
    end
    chk({tag, "_finish"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_accepted"}, 32'(i), 32'(exp_acc));
    chk({tag, "_word_count"}, 32'(word_count), 32'(exp_acc));
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_log_size"}, 32'(log0.size()), 32'(2 * exp_acc));
    errs = 0;
    if (log0.size() == 2 * exp_acc) begin
      for (int k = 0; k < exp_acc; k++) begin
        if (log0[2*k]   !== {16'(2*k),     words[k][15:8]}) errs++;
        if (log0[2*k+1] !== {16'(2*k + 1), words[k][7:0]})  errs++;
      end
    end
    chk({tag, "_log_bytes"}, 32'(errs), 32'd0);
  endtask

  typedef struct {
    int n;
    int last_idx;
    int exp_acc;
    bit exp_done;
    bit exp_ovf;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int n_rdy, prev, spacing_err, budget, acc, lr, n, last_idx;
    bit dn, ov;

    vecs[0] = '{n: 1,  last_idx: 0,  exp_acc: 1,  exp_done: 1'b1, exp_ovf: 1'b0};
    vecs[1] = '{n: 5,  last_idx: 2,  exp_acc: 3,  exp_done: 1'b1, exp_ovf: 1'b0};
    vecs[2] = '{n: 63, last_idx: 62, exp_acc: 63, exp_done: 1'b1, exp_ovf: 1'b0};
    vecs[3] = '{n: 64, last_idx: 63, exp_acc: 64, exp_done: 1'b1, exp_ovf: 1'b0};
    vecs[4] = '{n: 65, last_idx: -1, exp_acc: 64, exp_done: 1'b0, exp_ovf: 1'b1};
    vecs[5] = '{n: 70, last_idx: 69, exp_acc: 64, exp_done: 1'b0, exp_ovf: 1'b1};

    reset_n = 1'b0;
    start = 1'b0; word_valid = 1'b0; word_last = 1'b0; word_in = '0;
    start1 = 1'b0; word_valid1 = 1'b0; word_last1 = 1'b0; word_in1 = '0;
    #2;
    chk("rst_ready", 32'(word_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done_ovf_count", {done, overflow, word_count}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // two-word load with valid held, plus a Start pulse during WR_LO
    start = 1'b1; word_valid = 1'b1; word_in = 16'hA1B2; word_last = 1'b0;
    chk("t1_ready_on_start", 32'(word_ready), 32'd0);
    @(negedge clock);
    start = 1'b0;
    chk("t1_wait_ready", 32'(word_ready), 32'd1);
    chk("t1_wait_hold", 32'(cpu_hold), 32'd1);
    @(negedge clock);
    word_in = 16'hC3D4; word_last = 1'b1;
    chk("t1_hi0", {7'd0, mem_we, mem_addr, mem_data}, {7'd0, 1'b1, 16'd0, 8'hA1});
    chk("t1_hi0_ready", 32'(word_ready), 32'd0);
    @(negedge clock);
    start = 1'b1;
    chk("t1_lo0", {7'd0, mem_we, mem_addr, mem_data}, {7'd0, 1'b1, 16'd1, 8'hB2});
    @(negedge clock);
    start = 1'b0;
    chk("t1_wait2_ready", 32'(word_ready), 32'd1);
    chk("t1_start_ignored_count", 32'(word_count), 32'd1);
    chk("t1_wait2_we", 32'(mem_we), 32'd0);
    @(negedge clock);
    word_valid = 1'b0; word_last = 1'b0;
    chk("t1_hi1", {7'd0, mem_we, mem_addr, mem_data}, {7'd0, 1'b1, 16'd2, 8'hC3});
    @(negedge clock);
    chk("t1_lo1", {7'd0, mem_we, mem_addr, mem_data}, {7'd0, 1'b1, 16'd3, 8'hD4});
    chk("t1_lo1_hold", 32'(cpu_hold), 32'd1);
    @(negedge clock);
    chk("t1_hold_fall", 32'(cpu_hold), 32'd0);
    chk("t1_done", {done, overflow}, 32'b10);
    chk("t1_count", 32'(word_count), 32'd2);
    chk("t1_bus_holds", {7'd0, mem_we, mem_addr, mem_data}, {7'd0, 1'b0, 16'd3, 8'hD4});
    @(negedge clock);
    chk("t1_done_sticky", 32'(done), 32'd1);

    // valid held continuously, reset asserted in WR_HI of the third word
    log0.delete();
    start = 1'b1; word_valid = 1'b1; word_in = 16'h5A5A; word_last = 1'b0;
    @(negedge clock);
    start = 1'b0;
    n_rdy = 0; prev = 0; spacing_err = 0; budget = 0;
    while (!(mem_we && mem_addr == 16'd4) && budget < 40) begin
      if (word_ready) begin
        if (n_rdy > 0 && cyc - prev != 3) spacing_err++;
        prev = cyc;
        n_rdy++;
      end
      @(negedge clock);
      budget++;
    end
    chk("t4_reach_hi3", 32'(mem_we && mem_addr == 16'd4), 32'd1);
    chk("t5_accepts", 32'(n_rdy), 32'd3);
    chk("t5_spacing", 32'(spacing_err), 32'd0);
    chk("t5_not_consumed", 32'(word_ready), 32'd0);
    chk("t4_count_before", 32'(word_count), 32'd2);
    #1 reset_n = 1'b0;
    #1;
    chk("t4_rst_ready_we_hold", {word_ready, mem_we, cpu_hold}, 32'd0);
    chk("t4_rst_bus", {mem_addr, mem_data}, 32'd0);
    chk("t4_rst_status", {done, overflow, word_count}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    word_valid = 1'b0;
    @(negedge clock);
    run_load(2, 1, 2, 1'b1, 1'b0, "t4_reload");

    // second instance with a non-zero base address
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0; word_valid1 = 1'b1; word_in1 = 16'h1234; word_last1 = 1'b1;
    chk("t6_ready", 32'(word_ready1), 32'd1);
    @(negedge clock);
    word_valid1 = 1'b0; word_last1 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("t6_done", {done1, overflow1, cpu_hold1}, 32'b100);
    chk("t6_count", 32'(word_count1), 32'd1);
    chk("t6_log_size", 32'(log1.size()), 32'd2);
    if (log1.size() == 2) begin
      chk("t6_byte_hi", 32'(log1[0]), {8'd0, 16'd16, 8'h12});
      chk("t6_byte_lo", 32'(log1[1]), {8'd0, 16'd17, 8'h34});
    end

    for (int v = 0; v < 6; v++)
      run_load(vecs[v].n, vecs[v].last_idx, vecs[v].exp_acc,
               vecs[v].exp_done, vecs[v].exp_ovf, $sformatf("vec%0d", v));

    for (int r = 0; r < 15; r++) begin
      n = $urandom_range(1, 70);
      lr = $urandom_range(0, n);
      if (lr == n) last_idx = (n >= 64) ? -1 : n - 1;
      else last_idx = lr;
      model(n, last_idx, 0, acc, dn, ov);
      run_load(n, last_idx, acc, dn, ov, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
